// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 codes, FSM states, default width.
// Imported by the multiply/divide unit and its bench.
package riscv_m_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on a shared
// 2*XLEN accumulator, single-cycle registered writeback to the regfile.
module muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         funct3,
  input  logic [XLEN-1:0]    rs1_val,
  input  logic [XLEN-1:0]    rs2_val,
  input  logic [REGADDR-1:0] rd_in,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result,
  output logic [REGADDR-1:0] rd_out,
  output logic               ruwr
);

  localparam int CW = $clog2(XLEN);
  localparam int W2 = 2 * XLEN;
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  state_e             state_q, state_d;
  logic [2:0]         f3_q, f3_d;
  logic [REGADDR-1:0] rd_q, rd_d;
  logic [XLEN-1:0]    b_q, b_d;
  logic [W2-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               nq_q, nq_d;
  logic               nr_q, nr_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [REGADDR-1:0] rd_out_q, rd_out_d;
  logic               done_q, done_d;
  logic               ruwr_q, ruwr_d;

  logic               sa, sb;
  logic [XLEN-1:0]    a_mag, b_mag;
  logic               spec_zero, spec_ovf;
  logic [XLEN-1:0]    spec_val;

  always_comb begin
    sa = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
         (funct3 == F3_DIV)  || (funct3 == F3_REM);
    sb = (funct3 == F3_MULH) || (funct3 == F3_DIV) ||
         (funct3 == F3_REM);
    sa = sa && rs1_val[XLEN-1];
    sb = sb && rs2_val[XLEN-1];
    a_mag = sa ? -rs1_val : rs1_val;
    b_mag = sb ? -rs2_val : rs2_val;
    spec_zero = funct3[2] && (rs2_val == '0);
    spec_ovf = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (rs1_val == MINV) && (rs2_val == '1);
    // funct3[1] selects the remainder flavour of a divide
    if (funct3[1]) spec_val = spec_ovf ? '0 : rs1_val;
    else           spec_val = spec_ovf ? MINV : '1;
  end

  logic [XLEN:0]   sum;
  logic [XLEN:0]   r33;
  logic [XLEN:0]   diff;
  logic [W2-1:0]   acc_step;

  // mul: {hi,lo} with multiplier in lo, shift right
  // div: {rem,quo} shifted left, restoring subtract
  always_comb begin
    sum  = {1'b0, acc_q[W2-1:XLEN]} +
           (acc_q[0] ? {1'b0, b_q} : '0);
    r33  = acc_q[W2-1:XLEN-1];
    diff = r33 - {1'b0, b_q};
    if (f3_q[2]) begin
      if (diff[XLEN])
        acc_step = {r33[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else
        acc_step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {sum, acc_q[XLEN-1:1]};
    end
  end

  logic [W2-1:0]   prod;
  logic [XLEN-1:0] quo, rem, fin;

  always_comb begin
    prod = nq_q ? -acc_step : acc_step;
    quo  = nq_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = nr_q ? -acc_step[W2-1:XLEN] : acc_step[W2-1:XLEN];
    fin  = '0;
    unique case (f3_q)
      F3_MUL:                        fin = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fin = prod[W2-1:XLEN];
      F3_DIV, F3_DIVU:               fin = quo;
      F3_REM, F3_REMU:               fin = rem;
      default:                       fin = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    nq_d     = nq_q;
    nr_d     = nr_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          f3_d  = funct3;
          rd_d  = rd_in;
          b_d   = b_mag;
          acc_d = {{XLEN{1'b0}}, a_mag};
          cnt_d = '0;
          nq_d  = sa ^ sb;
          nr_d  = sa;
          if (spec_zero || spec_ovf) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = spec_val;
            rd_out_d = rd_in;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = fin;
            rd_out_d = rd_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ruwr_d = done_d && (rd_out_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      rd_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      nq_q     <= 1'b0;
      nr_q     <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
      ruwr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      nq_q     <= nq_d;
      nr_q     <= nr_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      done_q   <= done_d;
      ruwr_q   <= ruwr_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign ruwr   = ruwr_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model,
// per-cycle scoreboard, literal pins, latency/flush/reset cases.
module tb_muldiv_unit;
  import riscv_m_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, ruwr;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [31:0] exp_res_q[$];
  logic [4:0]  exp_rd_q[$];

  muldiv_unit #(.XLEN(32), .REGADDR(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .flush(flush), .busy(busy), .done(done), .result(result),
    .rd_out(rd_out), .ruwr(ruwr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    int ia = $signed(a);
    int ib = $signed(b);
    logic [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      F3_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
      F3_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      F3_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      F3_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      F3_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      F3_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        logic [31:0] r;
        logic [4:0]  d;
        done_cnt++;
        if (exp_res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got result=%h rd=%0d expected no done",
                   result, rd_out);
        end else begin
          r = exp_res_q.pop_front();
          d = exp_rd_q.pop_front();
          chk("sb_result", result, r);
          chk("sb_rd", 32'(rd_out), 32'(d));
          chk("sb_ruwr", 32'(ruwr), 32'(d != 0));
        end
      end else begin
        chk("ruwr_without_done", 32'(ruwr), 32'(0));
      end
    end
  end

  task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] lit, input int exp_lat,
                       input int restart_at);
    int lat;
    @(negedge clk);
    funct3 = f; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
    chk("model_pin", model(f, a, b), lit);
    exp_res_q.push_back(model(f, a, b));
    exp_rd_q.push_back(rd);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_on_accept", 32'(busy), 32'(1));
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == restart_at) begin
        start = 1'b1; funct3 = F3_MUL;
        rs1_val = 32'd3; rs2_val = 32'd3; rd_in = 5'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("dut_literal", result, lit);
    chk("rd_out", 32'(rd_out), 32'(rd));
    chk("ruwr", 32'(ruwr), 32'(rd != 0));
    @(posedge clk); #1;
    chk("done_drops", 32'(done), 32'(0));
    chk("busy_drops", 32'(busy), 32'(0));
    chk("result_holds", result, lit);
  endtask

  initial begin
    int dc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_ruwr", 32'(ruwr), 32'(0));
    chk("rst_result", result, 32'h0);
    chk("rst_rd_out", 32'(rd_out), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do_op(F3_MUL,    32'h7,         32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, 0);
    do_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33, 0);
    do_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33, 0);
    do_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 33, 0);
    do_op(F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd4, 32'hFFFF_FFFD, 33, 0);
    do_op(F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFF, 33, 0);
    do_op(F3_DIVU,   32'd100,       32'd7,         5'd7, 32'd14,        33, 0);
    do_op(F3_REMU,   32'd100,       32'd7,         5'd8, 32'd2,         33, 0);
    do_op(F3_DIV,    32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF, 1, 0);
    do_op(F3_REM,    32'd5,         32'd0,         5'd11, 32'd5,         1, 0);
    do_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, 0);
    do_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0,         1, 0);
    do_op(F3_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0,         33, 0);
    do_op(F3_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 33, 0);
    do_op(F3_DIVU,   32'd9,         32'd0,         5'd16, 32'hFFFF_FFFF, 1, 0);
    do_op(F3_MUL,    32'h1234_5678, 32'h9ABC_DEF0, 5'd17, 32'h242D_2080, 33, 0);

    do_op(F3_DIVU, 32'd1000, 32'd10, 5'd18, 32'd100, 33, 10);
    do_op(F3_MUL,  32'd6,    32'd7,  5'd0,  32'd42,  33, 0);

    // asynchronous reset in the middle of a divide
    dc = done_cnt;
    @(negedge clk);
    funct3 = F3_DIV; rs1_val = 32'd100; rs2_val = 32'd7;
    rd_in = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_ruwr", 32'(ruwr), 32'(0));
    chk("arst_result", result, 32'h0);
    chk("arst_rd_out", 32'(rd_out), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("arst_no_done", 32'(done_cnt), 32'(dc));

    // flush during CALC
    @(negedge clk);
    funct3 = F3_MULHU; rs1_val = 32'hFFFF_0000; rs2_val = 32'h1234;
    rd_in = 5'd21; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", 32'(busy), 32'(0));
    repeat (40) @(posedge clk);
    #1;
    chk("flush_no_done", 32'(done_cnt), 32'(dc));

    // flush and start together in IDLE
    @(negedge clk);
    flush = 1'b1; start = 1'b1; funct3 = F3_MUL;
    rs1_val = 32'd2; rs2_val = 32'd2; rd_in = 5'd22;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_beats_start", 32'(busy), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("flush_start_no_done", 32'(done_cnt), 32'(dc));

    do_op(F3_REM, 32'hFFFF_FF9C, 32'd7, 5'd23, 32'hFFFF_FFFE, 33, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_res_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
